pong_game_ctrl: RTL and testbench
=================================

Name: pong_game_ctrl

Overview:
- Round and score sequencer for the pong game.
- Sits between the ball-position module, the paddle logic and the VGA drawing path. Tells the ball module when to hold, when to serve and when to bounce horizontally.
- Detects paddle hits and misses, keeps both scores and declares a winner.
- All state advances on the 100 Hz game tick; the block itself runs on the 100 MHz system clock.

Parameters:
- PADDLE_X_L, 16: left paddle left edge (px).
- PADDLE_X_R, 616: right paddle left edge (px).
- PADDLE_W, 8: paddle width (px).
- PADDLE_H, 64: paddle height (px).
- WIN_SCORE, 7: points needed to win (1..15).
- SERVE_TICKS, 100: ticks the ball is held before a serve.
- SCORED_TICKS, 50: ticks of pause after a point.

Ports:
- clk  in  1  100 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- tick  in  1  one-clk pulse at 100 Hz; game-rate enable.
- start  in  1  level; begins a game from IDLE or GAME_OVER.
- ball_x  in  10  ball upper-left x.
- ball_y  in  9  ball upper-left y.
- ball_width  in  6  ball side length (px).
- paddle_l_y  in  9  left paddle top y.
- paddle_r_y  in  9  right paddle top y.
- ball_hold  out  1  ball module must park the ball at centre.
- serve_dir  out  1  horizontal direction for the next serve (0 = left, 1 = right).
- bounce_x  out  1  one-clk pulse: reverse ball x direction.
- score_l  out  4  left player score.
- score_r  out  4  right player score.
- state  out  3  current FSM state encoding, for display.
- game_over  out  1  high in GAME_OVER.
- winner  out  1  valid while game_over (0 = left, 1 = right).

Behaviour:
- Interface: one clock, clk. Reset is synchronous and active-high, port named reset.
- Reset values:
  - state = IDLE, ball_hold = 1, serve_dir = 1.
  - bounce_x = 0, scores = 0, game_over = 0, winner = 0.
  - dir = 1, counter = 0.
- Reset mid-game overrides everything in the same clk edge.
- All transitions and counter updates occur only on clk edges where tick = 1. bounce_x is asserted for exactly that one clk.
- Internal dir register holds the current horizontal travel direction. It is loaded from serve_dir at serve and toggled on each bounce.
- Geometry: all sums are 11-bit unsigned. No overflow is possible.
  - vl = (ball_y + ball_width > paddle_l_y) && (ball_y < paddle_l_y + PADDLE_H). vr is the same using paddle_r_y.
  - zone_l = ball_x <= PADDLE_X_L + PADDLE_W.
  - zone_r = ball_x + ball_width >= PADDLE_X_R.
  - hit_l = zone_l & vl & dir==0; miss_l = zone_l & !vl & dir==0. hit_r and miss_r mirror these with dir==1.
- FSM:
  - IDLE: ball_hold = 1. On start → SERVE, with scores cleared and counter = 0.
  - SERVE: ball_hold = 1. Counter increments each tick. At SERVE_TICKS-1 → PLAY, with dir = serve_dir and counter = 0.
  - PLAY: ball_hold = 0.
    - hit_l or hit_r: pulse bounce_x and toggle dir.
    - miss_l: score_r++ and serve_dir = 0 (serve toward the loser), then → SCORED.
    - miss_r: score_l++ and serve_dir = 1, then → SCORED.
    - Only the side matching dir is evaluated, so simultaneous zone_l and zone_r cannot both fire.
  - SCORED: ball_hold = 1. Counter runs to SCORED_TICKS-1.
    - If either score == WIN_SCORE → GAME_OVER, setting winner accordingly.
    - Otherwise → SERVE.
  - GAME_OVER: ball_hold = 1, game_over = 1. Scores are frozen. On start → SERVE with scores cleared.
- start is ignored in SERVE, PLAY and SCORED. Scores saturate at 15 and never wrap.

Optional Feature:
- Macro: PONG_SPEEDUP_EN.
- With the macro defined:
  - Extra output speed_lvl [1:0].
  - Rally counter counts bounces since the last serve. speed_lvl increments every 4 bounces, saturating at 3.
  - Counter and speed_lvl are cleared on entering SERVE and on reset.
- Without the macro: the port is absent and the ball runs at a fixed speed.

Decomposition:
- Package pong_pkg:
  - State enum: IDLE = 0, SERVE = 1, PLAY = 2, SCORED = 3, GAME_OVER = 4.
  - Coordinate widths: X_W = 10, Y_W = 9.
  - Screen constants: 640 x 480.
- One natural sub-module: pong_collide. Purely combinational; computes zone, vertical overlap and hit/miss for one paddle. Instantiated twice (left and right).

Test Plan:
- Reset asserted mid-PLAY with score_l = 3 → next clk: state = IDLE, scores 0/0, ball_hold = 1, bounce_x = 0.
- start pulse from IDLE, then 100 ticks → ball_hold falls on the 100th tick; dir = 1.
- PLAY, dir = 1, ball_x = 590, ball_width = 32, ball_y = 200, paddle_r_y = 180 → single bounce_x pulse on the tick. The next tick with the same inputs produces no pulse, because dir is now 0.
- PLAY, dir = 0, ball_x = 20, ball_y = 300, paddle_l_y = 100 → score_r 0→1, serve_dir = 0, state = SCORED. After 50 ticks, state = SERVE.
- score_l = 6, right miss → score_l = 7. After SCORED_TICKS: game_over = 1, winner = 0. tick with start = 0 stays in GAME_OVER; start = 1 → SERVE with scores 0/0.
- PONG_SPEEDUP_EN defined, 9 consecutive bounces → speed_lvl = 2. After the next miss and serve, speed_lvl = 0.

Source files
------------

// File: rtl/pong_pkg.sv
// Shared types and constants for the pong round/score sequencer.
// Contents: FSM state encoding, coordinate widths, screen size and a
// saturating score increment used by the controller.
package pong_pkg;

   localparam int unsigned X_W      = 10;
   localparam int unsigned Y_W      = 9;
   localparam int unsigned BW_W     = 6;
   localparam int unsigned SCORE_W  = 4;
   localparam int unsigned STATE_W  = 3;
   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef enum logic [STATE_W-1:0] {
      IDLE      = 3'd0,
      SERVE     = 3'd1,
      PLAY      = 3'd2,
      SCORED    = 3'd3,
      GAME_OVER = 3'd4
   } state_t;

   // Score increment that sticks at the all-ones value instead of wrapping.
   function automatic logic [SCORE_W-1:0] score_inc(input logic [SCORE_W-1:0] v);
      return (v == '1) ? v : v + SCORE_W'(1);
   endfunction

endpackage

// File: rtl/pong_game_ctrl_if.sv
// Ball/paddle link between the game controller and the ball-position and
// paddle modules.
//   master : the controller (reads geometry, drives ball control)
//   slave  : the ball/paddle side (drives geometry, reads ball control)
interface pong_game_ctrl_if;
   import pong_pkg::*;

   logic [X_W-1:0]  ball_x;
   logic [Y_W-1:0]  ball_y;
   logic [BW_W-1:0] ball_width;
   logic [Y_W-1:0]  paddle_l_y;
   logic [Y_W-1:0]  paddle_r_y;
   logic            ball_hold;
   logic            serve_dir;
   logic            bounce_x;

   modport master (
      input  ball_x, ball_y, ball_width, paddle_l_y, paddle_r_y,
      output ball_hold, serve_dir, bounce_x
   );

   modport slave (
      output ball_x, ball_y, ball_width, paddle_l_y, paddle_r_y,
      input  ball_hold, serve_dir, bounce_x
   );
endinterface

// File: rtl/pong_collide.sv
// Combinational paddle hit/miss detector for one side of the court.
// Ports: ball position/size, paddle top y, current travel direction dir;
//        hit_c / miss_c flag a ball in the paddle zone moving toward it,
//        with / without vertical overlap.
// RIGHT selects the right-side zone test and dir==1 as "approaching".
module pong_collide
   import pong_pkg::*;
#(
   parameter bit          RIGHT    = 1'b0,
   parameter int unsigned PADDLE_X = 16,
   parameter int unsigned PADDLE_W = 8,
   parameter int unsigned PADDLE_H = 64
) (
   input  logic [X_W-1:0]  ball_x,
   input  logic [Y_W-1:0]  ball_y,
   input  logic [BW_W-1:0] ball_width,
   input  logic [Y_W-1:0]  paddle_y,
   input  logic            dir,
   output logic            hit_c,
   output logic            miss_c
);

   localparam int unsigned S_W = 11;

   logic [S_W-1:0] ball_bot;
   logic [S_W-1:0] ball_rgt;
   logic [S_W-1:0] pad_bot;
   logic           vert;
   logic           zone;
   logic           toward;

   assign ball_bot = S_W'(ball_y) + S_W'(ball_width);
   assign ball_rgt = S_W'(ball_x) + S_W'(ball_width);
   assign pad_bot  = S_W'(paddle_y) + S_W'(PADDLE_H);

   assign vert   = (ball_bot > S_W'(paddle_y)) && (S_W'(ball_y) < pad_bot);
   assign zone   = RIGHT ? (ball_rgt >= S_W'(PADDLE_X))
                         : (S_W'(ball_x) <= S_W'(PADDLE_X + PADDLE_W));
   assign toward = RIGHT ? dir : ~dir;

   assign hit_c  = zone &  vert & toward;
   assign miss_c = zone & ~vert & toward;

endmodule

// File: rtl/pong_game_ctrl.sv
// Round and score sequencer for pong. Holds/serves/bounces the ball,
// detects paddle hits and misses, keeps scores and declares a winner.
// All state advances only on clk edges where tick (100 Hz) is high.
// Ports: clk, reset (sync, active-high), tick, start, bus (master side of
//        pong_game_ctrl_if: ball/paddle geometry in, ball_hold/serve_dir/
//        bounce_x out), score_l, score_r, state, game_over, winner.
// Optional: define PONG_SPEEDUP_EN to add speed_lvl, which rises by one
//           every 4 bounces in a rally (saturating at 3).
module pong_game_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned PADDLE_X_L   = 16,
   parameter int unsigned PADDLE_X_R   = 616,
   parameter int unsigned PADDLE_W     = 8,
   parameter int unsigned PADDLE_H     = 64,
   parameter int unsigned WIN_SCORE    = 7,
   parameter int unsigned SERVE_TICKS  = 100,
   parameter int unsigned SCORED_TICKS = 50
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                tick,
   input  logic                start,
   pong_game_ctrl_if.master    bus,
   output logic [SCORE_W-1:0]  score_l,
   output logic [SCORE_W-1:0]  score_r,
   output logic [STATE_W-1:0]  state,
   output logic                game_over,
`ifdef PONG_SPEEDUP_EN
   output logic [1:0]          speed_lvl,
`endif
   output logic                winner
);

   localparam int unsigned CNT_MAX = (SERVE_TICKS > SCORED_TICKS) ? SERVE_TICKS : SCORED_TICKS;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

   state_t               state_q,     state_d;
   logic [CNT_W-1:0]     cnt_q,       cnt_d;
   logic                 dir_q,       dir_d;
   logic                 serve_dir_q, serve_dir_d;
   logic                 hold_q,      hold_d;
   logic                 bounce_q,    bounce_d;
   logic [SCORE_W-1:0]   score_l_q,   score_l_d;
   logic [SCORE_W-1:0]   score_r_q,   score_r_d;
   logic                 over_q,      over_d;
   logic                 winner_q,    winner_d;
`ifdef PONG_SPEEDUP_EN
   logic [1:0]           rally_q,     rally_d;
   logic [1:0]           speed_q,     speed_d;
`endif

   logic hit_l_c, miss_l_c, hit_r_c, miss_r_c;

   pong_collide #(
      .RIGHT(1'b0), .PADDLE_X(PADDLE_X_L), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
   ) u_collide_l (
      .ball_x(bus.ball_x), .ball_y(bus.ball_y), .ball_width(bus.ball_width),
      .paddle_y(bus.paddle_l_y), .dir(dir_q), .hit_c(hit_l_c), .miss_c(miss_l_c)
   );

   pong_collide #(
      .RIGHT(1'b1), .PADDLE_X(PADDLE_X_R), .PADDLE_W(PADDLE_W), .PADDLE_H(PADDLE_H)
   ) u_collide_r (
      .ball_x(bus.ball_x), .ball_y(bus.ball_y), .ball_width(bus.ball_width),
      .paddle_y(bus.paddle_r_y), .dir(dir_q), .hit_c(hit_r_c), .miss_c(miss_r_c)
   );

   // State and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         dir_q       <= 1'b1;
         serve_dir_q <= 1'b1;
         hold_q      <= 1'b1;
         bounce_q    <= 1'b0;
         score_l_q   <= '0;
         score_r_q   <= '0;
         over_q      <= 1'b0;
         winner_q    <= 1'b0;
`ifdef PONG_SPEEDUP_EN
         rally_q     <= '0;
         speed_q     <= '0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         dir_q       <= dir_d;
         serve_dir_q <= serve_dir_d;
         hold_q      <= hold_d;
         bounce_q    <= bounce_d;
         score_l_q   <= score_l_d;
         score_r_q   <= score_r_d;
         over_q      <= over_d;
         winner_q    <= winner_d;
`ifdef PONG_SPEEDUP_EN
         rally_q     <= rally_d;
         speed_q     <= speed_d;
`endif
      end
   end

   // Next-state and next-output logic; only a tick can move anything.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      dir_d       = dir_q;
      serve_dir_d = serve_dir_q;
      bounce_d    = 1'b0;
      score_l_d   = score_l_q;
      score_r_d   = score_r_q;
      winner_d    = winner_q;
`ifdef PONG_SPEEDUP_EN
      rally_d     = rally_q;
      speed_d     = speed_q;
`endif

      if (tick) begin
         case (state_q)
            IDLE, GAME_OVER: begin
               if (start) begin
                  state_d   = SERVE;
                  cnt_d     = '0;
                  score_l_d = '0;
                  score_r_d = '0;
               end
            end
            SERVE: begin
               if (cnt_q == CNT_W'(SERVE_TICKS - 1)) begin
                  state_d = PLAY;
                  cnt_d   = '0;
                  dir_d   = serve_dir_q;
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            PLAY: begin
               if (hit_l_c || hit_r_c) begin
                  bounce_d = 1'b1;
                  dir_d    = ~dir_q;
`ifdef PONG_SPEEDUP_EN
                  rally_d  = rally_q + 2'(1);
                  if (rally_q == 2'd3 && speed_q != 2'd3)
                     speed_d = speed_q + 2'(1);
`endif
               end else if (miss_l_c) begin
                  // Loser receives the next serve.
                  score_r_d   = score_inc(score_r_q);
                  serve_dir_d = 1'b0;
                  state_d     = SCORED;
                  cnt_d       = '0;
               end else if (miss_r_c) begin
                  score_l_d   = score_inc(score_l_q);
                  serve_dir_d = 1'b1;
                  state_d     = SCORED;
                  cnt_d       = '0;
               end
            end
            SCORED: begin
               if (cnt_q == CNT_W'(SCORED_TICKS - 1)) begin
                  cnt_d = '0;
                  if (score_l_q == SCORE_W'(WIN_SCORE) || score_r_q == SCORE_W'(WIN_SCORE)) begin
                     state_d  = GAME_OVER;
                     winner_d = (score_r_q == SCORE_W'(WIN_SCORE));
                  end else begin
                     state_d = SERVE;
                  end
               end else begin
                  cnt_d = cnt_q + CNT_W'(1);
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end

`ifdef PONG_SPEEDUP_EN
      // Every fresh serve starts a new rally at base speed.
      if (state_d == SERVE && state_q != SERVE) begin
         rally_d = '0;
         speed_d = '0;
      end
`endif

      hold_d = (state_d != PLAY);
      over_d = (state_d == GAME_OVER);
   end

   assign bus.ball_hold = hold_q;
   assign bus.serve_dir = serve_dir_q;
   assign bus.bounce_x  = bounce_q;
   assign score_l       = score_l_q;
   assign score_r       = score_r_q;
   assign state         = STATE_W'(state_q);
   assign game_over     = over_q;
   assign winner        = winner_q;
`ifdef PONG_SPEEDUP_EN
   assign speed_lvl     = speed_q;
`endif

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl with hand-computed expectations.
// Covers the optional PONG_SPEEDUP_EN build when that macro is defined.
module tb_pong_game_ctrl;
   import pong_pkg::*;

   logic clk = 1'b0;
   logic reset;
   logic tick;
   logic start;
   logic [SCORE_W-1:0] score_l;
   logic [SCORE_W-1:0] score_r;
   logic [STATE_W-1:0] state;
   logic game_over;
   logic winner;
`ifdef PONG_SPEEDUP_EN
   logic [1:0] speed_lvl;
`endif

   int n_checks = 0;
   int n_errors = 0;

   pong_game_ctrl_if bus ();

   pong_game_ctrl dut (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .start     (start),
      .bus       (bus),
      .score_l   (score_l),
      .score_r   (score_r),
      .state     (state),
      .game_over (game_over),
`ifdef PONG_SPEEDUP_EN
      .speed_lvl (speed_lvl),
`endif
      .winner    (winner)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Called at a negedge; one tick pulse, returns at the following negedge.
   task automatic do_tick();
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) begin
         do_tick();
         @(negedge clk);
      end
   endtask

   task automatic set_ball(input int x, input int y, input int w);
      bus.ball_x     = X_W'(x);
      bus.ball_y     = Y_W'(y);
      bus.ball_width = BW_W'(w);
   endtask

   // From PLAY with dir=1: right miss, then wait out SCORED and SERVE.
   task automatic score_left_point();
      set_ball(600, 400, 32);
      bus.paddle_r_y = 9'd100;
      do_tick();
      @(negedge clk);
      set_ball(300, 200, 8);
      tick_n(50 + 100);
   endtask

   initial begin
      reset = 1'b1;
      tick  = 1'b0;
      start = 1'b0;
      set_ball(300, 200, 8);
      bus.paddle_l_y = 9'd180;
      bus.paddle_r_y = 9'd180;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      check_eq("rst_state",     32'(state),         32'd0);
      check_eq("rst_hold",      32'(bus.ball_hold), 32'd1);
      check_eq("rst_serve_dir", 32'(bus.serve_dir), 32'd1);
      check_eq("rst_bounce",    32'(bus.bounce_x),  32'd0);
      check_eq("rst_scores",    32'({score_l, score_r}), 32'd0);
      check_eq("rst_over",      32'({game_over, winner}), 32'd0);

      // start needs a tick; a tick alone leaves IDLE untouched
      tick_n(1);
      check_eq("idle_no_start", 32'(state), 32'd0);
      start = 1'b1;
      do_tick();
      start = 1'b0;
      check_eq("serve_entry", 32'(state), 32'd1);
      @(negedge clk);
      tick_n(99);
      check_eq("serve_99_state", 32'(state),         32'd1);
      check_eq("serve_99_hold",  32'(bus.ball_hold), 32'd1);
      tick_n(1);
      check_eq("serve_100_state", 32'(state),         32'd2);
      check_eq("serve_100_hold",  32'(bus.ball_hold), 32'd0);

      // right paddle hit with dir=1, then same inputs give nothing
      set_ball(590, 200, 32);
      bus.paddle_r_y = 9'd180;
      do_tick();
      check_eq("bounce_r_pulse", 32'(bus.bounce_x), 32'd1);
      @(negedge clk);
      check_eq("bounce_r_width", 32'(bus.bounce_x), 32'd0);
      do_tick();
      check_eq("bounce_r_again", 32'(bus.bounce_x), 32'd0);
      check_eq("bounce_r_state", 32'(state),        32'd2);
      @(negedge clk);

      // left miss with dir=0
      set_ball(20, 300, 8);
      bus.paddle_l_y = 9'd100;
      do_tick();
      check_eq("miss_l_score_r",   32'(score_r),       32'd1);
      check_eq("miss_l_score_l",   32'(score_l),       32'd0);
      check_eq("miss_l_serve_dir", 32'(bus.serve_dir), 32'd0);
      check_eq("miss_l_state",     32'(state),         32'd3);
      check_eq("miss_l_hold",      32'(bus.ball_hold), 32'd1);
      @(negedge clk);
      set_ball(300, 200, 8);
      tick_n(49);
      check_eq("scored_49", 32'(state), 32'd3);
      tick_n(1);
      check_eq("scored_50", 32'(state), 32'd2 - 32'd1);
      tick_n(100);
      check_eq("play_dir0", 32'(state), 32'd2);

      // left hit flips dir back to 1
      set_ball(20, 120, 8);
      do_tick();
      check_eq("bounce_l_pulse", 32'(bus.bounce_x), 32'd1);
      @(negedge clk);
      set_ball(300, 200, 8);

      for (int i = 0; i < 3; i++) score_left_point();
      check_eq("pre_rst_score_l", 32'(score_l), 32'd3);
      check_eq("pre_rst_state",   32'(state),   32'd2);

      // reset coinciding with a tick and a hit: reset wins
      set_ball(590, 200, 32);
      bus.paddle_r_y = 9'd180;
      reset = 1'b1;
      tick  = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      tick  = 1'b0;
      check_eq("midrst_state",  32'(state),         32'd0);
      check_eq("midrst_scores", 32'({score_l, score_r}), 32'd0);
      check_eq("midrst_hold",   32'(bus.ball_hold), 32'd1);
      check_eq("midrst_bounce", 32'(bus.bounce_x),  32'd0);
`ifdef PONG_SPEEDUP_EN
      check_eq("midrst_speed",  32'(speed_lvl),     32'd0);
`endif

      // play a left-player win
      set_ball(300, 200, 8);
      start = 1'b1;
      do_tick();
      start = 1'b0;
      @(negedge clk);
      tick_n(100);
      for (int i = 0; i < 6; i++) score_left_point();
      check_eq("six_score_l", 32'(score_l), 32'd6);
      set_ball(600, 400, 32);
      bus.paddle_r_y = 9'd100;
      do_tick();
      check_eq("seven_score_l", 32'(score_l), 32'd7);
      check_eq("seven_state",   32'(state),   32'd3);
      @(negedge clk);
      set_ball(300, 200, 8);
      tick_n(49);
      check_eq("seven_still_scored", 32'(state), 32'd3);
      tick_n(1);
      check_eq("gover_state",  32'(state),     32'd4);
      check_eq("gover_flag",   32'(game_over), 32'd1);
      check_eq("gover_winner", 32'(winner),    32'd0);
      check_eq("gover_hold",   32'(bus.ball_hold), 32'd1);
      tick_n(3);
      check_eq("gover_stay",   32'(state),   32'd4);
      check_eq("gover_frozen", 32'(score_l), 32'd7);
      start = 1'b1;
      do_tick();
      start = 1'b0;
      check_eq("restart_state",  32'(state),     32'd1);
      check_eq("restart_scores", 32'({score_l, score_r}), 32'd0);
      check_eq("restart_over",   32'(game_over), 32'd0);
      @(negedge clk);

`ifdef PONG_SPEEDUP_EN
      // serve_dir is still 1, so rally starts toward the right paddle
      tick_n(100);
      bus.paddle_l_y = 9'd180;
      bus.paddle_r_y = 9'd180;
      for (int i = 0; i < 9; i++) begin
         set_ball((i % 2 == 0) ? 590 : 20, 200, 32);
         do_tick();
         check_eq("rally_bounce", 32'(bus.bounce_x), 32'd1);
         @(negedge clk);
      end
      check_eq("speed_after_9", 32'(speed_lvl), 32'd2);
      // dir is now 0: left miss
      set_ball(20, 200, 32);
      bus.paddle_l_y = 9'd400;
      do_tick();
      check_eq("speed_miss_state", 32'(state),     32'd3);
      check_eq("speed_held",       32'(speed_lvl), 32'd2);
      @(negedge clk);
      set_ball(300, 200, 8);
      tick_n(50);
      check_eq("speed_serve_state", 32'(state),     32'd1);
      check_eq("speed_cleared",     32'(speed_lvl), 32'd0);
`endif

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
